// File: rtl/si_arbiter_pkg.sv
// si_arbiter_pkg: arbiter state type, drop counter width and round-robin pick helper
package si_arbiter_pkg;
  typedef enum logic {IDLE, FORWARD} state_t;
  localparam int DROP_COUNT_WIDTH = 32;
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] last, input int n);
    logic [4:0] r;
    int idx;
    r = '0;
    for (int k = 16; k >= 1; k--) begin
      idx = (int'(last) + k) % n;
      if (k <= n && req[idx]) r = {1'b1, 4'(idx)};
    end
    return r;
  endfunction
endpackage

// File: rtl/si_axis_skid_buffer.sv
// si_axis_skid_buffer: 2-entry registered output stage; s_* beat in (s_ready from a register), m_* registered beat out, user carries the source id
module si_axis_skid_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [KEEP_WIDTH-1:0] s_keep,
  input  logic                  s_last,
  input  logic [USER_WIDTH-1:0] s_user,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [KEEP_WIDTH-1:0] m_keep,
  output logic                  m_last,
  output logic [USER_WIDTH-1:0] m_user
);
  localparam int W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  logic [W-1:0] in_w, out_w, skid_w;
  logic skid_valid;
  assign in_w = {s_data, s_keep, s_last, s_user};
  assign {m_data, m_keep, m_last, m_user} = out_w;
  assign s_ready = !skid_valid;
  always_ff @(posedge clk)
    if (rst) begin
      m_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!m_valid || m_ready) begin
      m_valid <= skid_valid || s_valid;
      skid_valid <= 1'b0;
      out_w <= skid_valid ? skid_w : in_w;
    end else if (s_valid && s_ready) begin
      skid_valid <= 1'b1;
      skid_w <= in_w;
    end
endmodule

// File: rtl/si_packet_arbiter.sv
// si_packet_arbiter: packet-atomic round-robin merge of NUM_INPUTS AXI4-Stream inputs; cfg_enable masks inputs, disabled/fragment inputs are drained and counted in drop_count, busy marks FORWARD
module si_packet_arbiter
  import si_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_INPUTS-1:0]          cfg_enable,
  input  logic [NUM_INPUTS-1:0]          s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]          s_axis_tready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_INPUTS-1:0]          s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  output logic [DROP_COUNT_WIDTH-1:0]    drop_count,
  output logic                           busy
);
  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam int DW = DROP_COUNT_WIDTH + 1;
  state_t state;
  logic [ID_WIDTH-1:0] grant, last_grant;
  logic [NUM_INPUTS-1:0] drop_active, drain, eligible;
  logic [4:0] pick;
  logic fwd_valid, fwd_ready, fwd_last;
  logic [CW-1:0] n_drop;
  logic [DW-1:0] drop_sum;
  assign busy = state == FORWARD;
  assign eligible = cfg_enable & ~drop_active & s_axis_tvalid;
  assign pick = rr_pick(16'(eligible), 4'(last_grant), NUM_INPUTS);
  assign fwd_valid = busy && s_axis_tvalid[grant];
  assign fwd_last = s_axis_tlast[grant];
  assign drop_sum = {1'b0, drop_count} + DW'(n_drop);
  always_comb begin
    drain = '0;
    s_axis_tready = '0;
    n_drop = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      drain[i] = !(busy && grant == ID_WIDTH'(i)) && (!cfg_enable[i] || drop_active[i]);
      s_axis_tready[i] = (busy && grant == ID_WIDTH'(i)) ? fwd_ready : drain[i];
      n_drop = n_drop + CW'(drain[i] && s_axis_tvalid[i] && s_axis_tlast[i]);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= ID_WIDTH'(NUM_INPUTS - 1);
      drop_active <= '0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++)
        if (drain[i] && s_axis_tvalid[i]) drop_active[i] <= !s_axis_tlast[i];
      drop_count <= drop_sum[DW-1] ? '1 : drop_sum[DROP_COUNT_WIDTH-1:0];
      if (state == IDLE && pick[4]) begin
        grant <= ID_WIDTH'(pick[3:0]);
        state <= FORWARD;
      end
      if (fwd_valid && fwd_ready && fwd_last) begin
        last_grant <= grant;
        state <= IDLE;
      end
    end
  si_axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .USER_WIDTH(ID_WIDTH)
  ) u_skid (
    .clk(clk),
    .rst(rst),
    .s_valid(fwd_valid),
    .s_ready(fwd_ready),
    .s_data(s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH]),
    .s_keep(s_axis_tkeep[grant*KEEP_WIDTH +: KEEP_WIDTH]),
    .s_last(fwd_last),
    .s_user(grant),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready),
    .m_data(m_axis_tdata),
    .m_keep(m_axis_tkeep),
    .m_last(m_axis_tlast),
    .m_user(m_axis_tid)
  );
endmodule

// File: doc/si_packet_arbiter.md
Name: si_packet_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges NUM_INPUTS AXI4-Stream time-tag packet streams into one stream feeding si_header_detacher.
- Grants one input per packet, holds the grant until tlast and tags every output beat with its source index.
- A runtime enable mask configures which inputs are forwarded. Disabled inputs are drained so they never stall their source. Dropped packets are counted.

Parameters:
- NUM_INPUTS, 4, number of slave streams, 2..16
- DATA_WIDTH, 128, tdata width, shared with si_header_detacher
- KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width
- ID_WIDTH, $clog2(NUM_INPUTS), width of source index

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_enable  in  NUM_INPUTS  per-input forward enable
- s_axis_tvalid  in  NUM_INPUTS  per-input valid
- s_axis_tready  out  NUM_INPUTS  per-input ready
- s_axis_tdata  in  NUM_INPUTS*DATA_WIDTH  input i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  NUM_INPUTS*KEEP_WIDTH  packed like tdata
- s_axis_tlast  in  NUM_INPUTS  per-input last
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  output keep
- m_axis_tlast  out  1  output last
- m_axis_tid  out  ID_WIDTH  source index of current beat
- drop_count  out  32  packets discarded, saturating
- busy  out  1  high in FORWARD

Behaviour:
- Reset: state=IDLE, last_grant=NUM_INPUTS-1, drop_active=0, drop_count=0, skid buffer empty, m_axis_tvalid=0, s_axis_tready=0, busy=0.
- Reset mid-packet truncates the forwarded packet. si_header_detacher shares rst, so downstream resynchronises.
- Eligibility: input i is eligible iff cfg_enable[i]=1 and drop_active[i]=0 and s_axis_tvalid[i]=1.
- IDLE:
  - No input is granted.
  - Search starts at (last_grant+1) mod NUM_INPUTS, upward with wrap. The first eligible input is latched into grant, and the next cycle is FORWARD.
  - If no input is eligible, stay in IDLE.
  - Cost: one bubble cycle per packet.
- FORWARD:
  - s_axis_tready[grant] = skid-buffer input ready. The beat is pushed with tid=grant.
  - On an accepted beat with tlast=1: last_grant<=grant, next state IDLE.
  - Deasserting cfg_enable[grant] mid-packet does not revoke the grant. The packet completes intact, and the change takes effect at the next arbitration.
- Drain of non-granted inputs:
  - An input is drained if it is not granted and either cfg_enable[i]=0 or drop_active[i]=1. Drained inputs have s_axis_tready[i]=1 and their beats are discarded.
  - drop_active[i] is set on a discarded beat with tlast=0 and cleared on a discarded beat with tlast=1.
  - Re-enabling an input mid-packet keeps draining until tlast, so headerless fragments never reach the detacher.
- Other inputs: an enabled, non-granted input with drop_active=0 has tready=0 (back-pressured).
- drop_count increments once per discarded beat with tlast=1. It saturates at 32'hFFFF_FFFF.
- Output stage:
  - 2-entry skid buffer, fully registered outputs, 1-cycle latency from input accept to m_axis_tvalid.
  - Sustains 1 beat/cycle within a packet under continuous m_axis_tready.
  - Holds tdata/tkeep/tlast/tid stable while tvalid=1 and tready=0.
- Simultaneous events:
  - A granted tlast accept and a drain on another input in the same cycle are independent.
  - A drain tlast and a drop_count increment in the same cycle count normally.
- Fairness: each enabled input that holds tvalid is granted within NUM_INPUTS-1 packets of other inputs.

Decomposition:
- Package si_arbiter_pkg: state enum (IDLE, FORWARD), DROP_COUNT_WIDTH=32 and a round-robin next-index function.
- Sub-module si_axis_skid_buffer holds the registered output stage. Parameters are DATA_WIDTH, KEEP_WIDTH and USER_WIDTH, with tid carried as user.

Test Plan:
- Inputs 0 and 2 each send continuous 3-beat packets, cfg_enable=4'b1111, m_axis_tready=1 -> output packet order 0,2,0,2, tid matches, each packet 3 contiguous beats, 1 idle cycle between packets.
- Input 1 sends a 4-beat packet; m_axis_tready toggles 1,0,1,0 -> no beat lost or duplicated, data stable during stall, tlast on the 4th output beat only.
- cfg_enable=4'b1101 and input 1 sends 5 packets of 2 beats -> s_axis_tready[1]=1 throughout, no output, drop_count=5.
- Input 3 starts a 4-beat packet while disabled; cfg_enable[3] is set after beat 2, then a new 2-beat packet follows -> beats 3-4 discarded, drop_count+1, second packet forwarded intact with tid=3.
- cfg_enable[0] is cleared on beat 2 of a 6-beat granted packet on input 0 -> all 6 beats forwarded, then input 0 is drained.
- rst is asserted mid-packet on input 2 -> next cycle m_axis_tvalid=0, s_axis_tready=0, drop_count=0, and the first grant after reset goes to input 0.
